nn_inference_sequencer: RTL
===========================

// Module: nn_inference_sequencer
// PURPOSE
//  Front-end controller for the NeuralNetwork top: gathers one frame of pixels from a serial
//  valid/ready stream into the wide NNin bus, fires a one-cycle NNvalid, then waits for maxValid.
//  It captures maxIndex/maxValue into a result register held under a valid/ready handshake, and
//  guards against malformed frames and a hung network (timeout). Sits between pixel source and NN.
// PARAMETERS
//  NUM_INPUTS      784     pixels per frame; NNin width = NUM_INPUTS*DATA_W
//  DATA_W          16      pixel / maxValue width (Q8.8)
//  CLASS_W         4       maxIndex width
//  TIMEOUT_CYCLES  100000  max WAIT cycles before abort (>=2)
//  CNT_W / TO_W    derived $clog2(NUM_INPUTS) / $clog2(TIMEOUT_CYCLES+1), localparams
// PORTS
//  clk          in   1                  single clock, rising edge
//  reset        in   1                  asynchronous, active-high
//  pix_data     in   DATA_W             pixel value
//  pix_valid    in   1                  pixel present
//  pix_last     in   1                  marks final pixel of frame (qualified by pix_valid&pix_ready)
//  pix_ready    out  1                  sequencer accepts pixel this cycle
//  NNin         out  NUM_INPUTS*DATA_W  frame to NN; pixel i at [i*DATA_W +: DATA_W]
//  NNvalid      out  1                  one-cycle start pulse to NN
//  maxValid     in   1                  NN result strobe
//  maxIndex     in   CLASS_W            NN winning class
//  maxValue     in   DATA_W             NN winning score
//  res_class    out  CLASS_W            captured class
//  res_value    out  DATA_W             captured score
//  res_valid    out  1                  result available; held until res_ready
//  res_ready    in   1                  consumer takes result
//  busy         out  1                  high in FIRE/WAIT/HOLD
//  frame_err    out  1                  one-cycle pulse: pix_last/count mismatch, frame dropped
//  timeout_err  out  1                  one-cycle pulse: WAIT expired
//  frame_count  out  16                 completed inferences, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async): state=LOAD, pixel count=0, NNin=0, all outputs 0 except pix_ready=1 (combinational of LOAD).
//  LOAD: pix_ready=1. On accept, NNin[cnt*DATA_W +: DATA_W]<=pix_data, cnt++.
//   Accept with cnt==NUM_INPUTS-1 and pix_last=1 -> FIRE, cnt<=0.
//   pix_last=1 with cnt<NUM_INPUTS-1, or cnt==NUM_INPUTS-1 with pix_last=0 -> frame_err pulse next
//   cycle, cnt<=0, stay LOAD (NNin contents stale, not cleared).
//  FIRE: NNvalid=1 exactly one cycle, pix_ready=0 -> WAIT, timer<=0. Last accept at T => NNvalid at T+1.
//  WAIT: timer++ each cycle. maxValid=1 -> res_class/res_value<=maxIndex/maxValue, res_valid<=1,
//   frame_count++, -> HOLD (res_valid visible cycle after maxValid). timer==TIMEOUT_CYCLES-1 without
//   maxValid -> timeout_err pulse, -> LOAD. maxValid in the expiry cycle: result wins, no timeout_err.
//  HOLD: res_valid=1, res_* stable; res_ready=1 -> res_valid<=0, -> LOAD (pix_ready=1 next cycle).
//  NNin never changes outside LOAD; pix_ready=0 in FIRE/WAIT/HOLD. maxValid outside WAIT ignored.
//  res_ready outside HOLD ignored. Reset mid-frame/mid-WAIT discards all state; later maxValid ignored.
// STRUCTURE
//  nn_pkg: state enum {LOAD,FIRE,WAIT,HOLD}, defaults NUM_INPUTS/DATA_W/CLASS_W.
//  Sub-module nn_input_buffer: indexed-write frame register (wr_en, wr_idx, wr_data -> NNin flat bus).
//  Top: FSM, pixel counter, timeout counter, result register, frame counter.
// TESTING (NN stubbed by a bench model returning maxValid after programmable delay)
//  Reset: assert reset async mid-cycle -> all outputs 0 immediately, pix_ready=1 after release.
//  Frame pix i=i, pix_last on i=783 -> NNin[15:0]=0, NNin[783*16+:16]=16'h030F, single NNvalid at T+1;
//   stub maxValid after 50 cycles with maxIndex=7, maxValue=16'h0A80 -> res_valid=1, res_class=7,
//   res_value=16'h0A80 held 10 cycles with res_ready=0; res_ready=1 -> res_valid=0, frame_count=1.
//  pix_last at pixel 100 -> frame_err 1-cycle pulse, no NNvalid; next full frame infers normally.
//  TIMEOUT_CYCLES=64, stub silent -> timeout_err pulse 64 cycles after WAIT entry, back to LOAD, res_valid stays 0.
//  Random pix_valid gaps + stray maxValid in LOAD/HOLD -> identical NNin, exactly one result per frame.
//  Reset during WAIT, stub fires maxValid afterwards -> res_valid stays 0, frame_count stays 0.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and default sizing for the NN inference
//               sequencer slice: sequencer state encoding and the default
//               frame / pixel / class geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Default frame geometry: 28x28 pixels, Q8.8 samples, 10 classes.
    localparam int c_num_inputs     = 784;
    localparam int c_data_w         = 16;
    localparam int c_class_w        = 4;
    localparam int c_timeout_cycles = 100000;

    // LOAD : collecting pixels
    // FIRE : one-cycle start pulse to the network
    // WAIT : waiting for the network result (bounded by the timeout)
    // HOLD : result presented until the consumer takes it
    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } nn_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : nn_input_buffer
// Description : Indexed-write frame register. One DATA_W slot per pixel;
//               a write stores wr_data into slot wr_idx. All slots are
//               presented side by side on the flat NNin bus, pixel i at
//               NNin[i*DATA_W +: DATA_W].
// Ports       : clk, reset (async, active-high)
//               wr_en   - write strobe
//               wr_idx  - slot index of the write
//               wr_data - pixel value to store
//               NNin    - flat frame bus
// Revision    : 1.0 - initial release
// ============================================================================
module nn_input_buffer
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = c_num_inputs,
    parameter int DATA_W     = c_data_w,
    parameter int IDX_W      = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [NUM_INPUTS*DATA_W-1:0] NNin
);

    // One register per pixel with its own decoded enable, so only the
    // addressed slot toggles on a write.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_pix
        logic [DATA_W-1:0] r_pix;
        logic              w_sel;

        assign w_sel = wr_en && (wr_idx == IDX_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pix <= '0;
            end else if (w_sel) begin
                r_pix <= wr_data;
            end
        end

        assign NNin[i*DATA_W +: DATA_W] = r_pix;
    end

endmodule : nn_input_buffer
`default_nettype wire

// File: rtl/nn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nn_inference_sequencer
// Description : Front-end controller for the neural-network core. Collects
//               one frame of pixels from a valid/ready stream into NNin,
//               fires a one-cycle NNvalid, waits (bounded) for maxValid,
//               then holds the captured class/score under a valid/ready
//               handshake. Malformed frames are dropped with frame_err;
//               a silent network is abandoned with timeout_err.
// Ports       : clk, reset (async, active-high)
//               pix_data/pix_valid/pix_last/pix_ready - pixel stream in
//               NNin, NNvalid                         - frame + start to NN
//               maxValid/maxIndex/maxValue            - NN result strobe
//               res_class/res_value/res_valid/res_ready - result out
//               busy, frame_err, timeout_err, frame_count - status
// Revision    : 1.0 - initial release
// ============================================================================
module nn_inference_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS     = c_num_inputs,
    parameter int DATA_W         = c_data_w,
    parameter int CLASS_W        = c_class_w,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            pix_data,
    input  logic                         pix_valid,
    input  logic                         pix_last,
    output logic                         pix_ready,
    output logic [NUM_INPUTS*DATA_W-1:0] NNin,
    output logic                         NNvalid,
    input  logic                         maxValid,
    input  logic [CLASS_W-1:0]           maxIndex,
    input  logic [DATA_W-1:0]            maxValue,
    output logic [CLASS_W-1:0]           res_class,
    output logic [DATA_W-1:0]            res_value,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         timeout_err,
    output logic [15:0]                  frame_count
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_INPUTS - 1);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT_CYCLES - 1);

    nn_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [TO_W-1:0]      r_timer;
    logic                 r_nnvalid;
    logic [CLASS_W-1:0]   r_res_class;
    logic [DATA_W-1:0]    r_res_value;
    logic                 r_res_valid;
    logic                 r_frame_err;
    logic                 r_timeout_err;
    logic [15:0]          r_frame_count;

    logic                 w_load;
    logic                 w_accept;
    logic                 w_at_end;

    assign w_load   = (r_state == S_LOAD);
    assign w_accept = w_load && pix_valid;
    assign w_at_end = (r_cnt == c_last_idx);

    // Every accepted pixel is written, including those of a frame that is
    // later rejected; the buffer is simply overwritten by the next frame.
    nn_input_buffer #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_W     (DATA_W),
        .IDX_W      (CNT_W)
    ) u_input_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_accept),
        .wr_idx  (r_cnt),
        .wr_data (pix_data),
        .NNin    (NNin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_nnvalid     <= 1'b0;
            r_res_class   <= '0;
            r_res_value   <= '0;
            r_res_valid   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_count <= '0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            r_nnvalid     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;

            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_at_end && pix_last) begin
                            r_cnt     <= '0;
                            r_nnvalid <= 1'b1;
                            r_state   <= S_FIRE;
                        end else if (w_at_end || pix_last) begin
                            // Frame length and pix_last disagree: drop it.
                            r_cnt       <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                S_FIRE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_timer <= r_timer + TO_W'(1);
                    // A result arriving in the expiry cycle takes priority.
                    if (maxValid) begin
                        r_res_class   <= maxIndex;
                        r_res_value   <= maxValue;
                        r_res_valid   <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= S_HOLD;
                    end else if (r_timer == c_to_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end

                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign pix_ready   = w_load;
    assign busy        = !w_load;
    assign NNvalid     = r_nnvalid;
    assign res_class   = r_res_class;
    assign res_value   = r_res_value;
    assign res_valid   = r_res_valid;
    assign frame_err   = r_frame_err;
    assign timeout_err = r_timeout_err;
    assign frame_count = r_frame_count;

endmodule : nn_inference_sequencer
`default_nettype wire
